// File: rtl/param_cam_pkg.sv
// Shared encodings for the parameterised CAM: the operation codes and
// the states of the control FSM.
package param_cam_pkg;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_WRITE  = 2'd1,
    OP_INVAL  = 2'd2,
    OP_ALLOC  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Priority encoder: flags whether any bit of vec_i is set, gives the
// lowest set index, and flags whether more than one bit is set.
module cam_prio_enc #(
  parameter int N     = 14,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     vec_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             multi_o
);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o   = |vec_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(vec_i & (vec_i - N'(1)));

endmodule

// File: rtl/param_cam.sv
// Small content-addressable memory with search, write, invalidate and
// allocate operations, plus a one-entry-per-cycle flush sequencer.
module param_cam
  import param_cam_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 14,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_data,
  input  logic              flush,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_multi,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d, match;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] flush_idx_q, flush_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic              rsp_multi_q, rsp_multi_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              m_any, m_multi, f_any, f_multi_unused;
  logic [ADDR_W-1:0] m_idx, f_idx;
  logic              addr_in_range;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) match[i] = valid_q[i] && (data_q[i] == op_data);
  end

  cam_prio_enc #(.N(DEPTH), .IDX_W(ADDR_W)) u_match_enc (
    .vec_i(match), .any_o(m_any), .idx_o(m_idx), .multi_o(m_multi)
  );

  cam_prio_enc #(.N(DEPTH), .IDX_W(ADDR_W)) u_free_enc (
    .vec_i(~valid_q), .any_o(f_any), .idx_o(f_idx), .multi_o(f_multi_unused)
  );

  assign addr_in_range = ({1'b0, op_addr} < (ADDR_W + 1)'(DEPTH));

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    valid_d     = valid_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_multi_d = 1'b0;
    rsp_addr_d  = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A flush request wins over a simultaneous operation.
        if (flush) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end else if (op_valid) begin
          rsp_valid_d = 1'b1;
          unique case (op_e'(op_code))
            OP_SEARCH: begin
              rsp_hit_d   = m_any;
              rsp_multi_d = m_multi;
              rsp_addr_d  = m_idx;
            end
            OP_WRITE: if (addr_in_range) begin
              valid_d[op_addr] = 1'b1;
              wr_en            = 1'b1;
              wr_addr          = op_addr;
              rsp_hit_d        = 1'b1;
              rsp_addr_d       = op_addr;
            end
            OP_INVAL: if (addr_in_range) begin
              rsp_hit_d        = valid_q[op_addr];
              valid_d[op_addr] = 1'b0;
              rsp_addr_d       = op_addr;
            end
            OP_ALLOC: if (f_any) begin
              valid_d[f_idx] = 1'b1;
              wr_en          = 1'b1;
              wr_addr        = f_idx;
              rsp_hit_d      = 1'b1;
              rsp_addr_d     = f_idx;
            end
          endcase
        end
      end
      ST_FLUSH: begin
        valid_d[flush_idx_q] = 1'b0;
        if (flush_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
        else flush_idx_d = flush_idx_q + ADDR_W'(1);
      end
    endcase
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CNT_W'(valid_d[i]);
    full_d = (count_d == CNT_W'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_multi_q <= 1'b0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      full_q      <= full_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_multi_q <= rsp_multi_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  // NOTE: the data array has no reset; a clear valid bit masks stale contents,
  // which keeps the storage free of reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_addr] <= op_data;
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_multi = rsp_multi_q;
  assign rsp_addr  = rsp_addr_q;
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: tb/tb_param_cam.sv
// Self-checking bench for param_cam: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_param_cam;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 14;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [1:0]        op_code = '0;
  logic [ADDR_W-1:0] op_addr = '0;
  logic [DATA_W-1:0] op_data = '0;
  logic              flush = 1'b0;
  logic              rsp_valid, rsp_hit, rsp_multi;
  logic [ADDR_W-1:0] rsp_addr;
  logic              full;
  logic [CNT_W-1:0]  count;

  param_cam #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_addr(op_addr), .op_data(op_data), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_multi(rsp_multi),
    .rsp_addr(rsp_addr), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a list of entries plus a flush countdown.
  bit          mvalid [DEPTH];
  logic [7:0]  mdata  [DEPTH];
  int          flush_left = 0;
  bit          chk_en = 0;
  bit          exp_rsp_valid = 0, exp_hit = 0, exp_multi = 0;
  bit          exp_addr_chk = 0, exp_is_search = 0, exp_ready = 1, exp_full = 0;
  int          exp_addr = 0, exp_count = 0;

  always @(posedge clk) begin
    int a, n;
    exp_rsp_valid = 0; exp_hit = 0; exp_multi = 0; exp_addr = 0;
    exp_addr_chk = 0; exp_is_search = 0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mvalid[i] = 0;
      flush_left = 0;
      chk_en = 1;
    end else if (flush_left > 0) begin
      mvalid[DEPTH - flush_left] = 0;
      flush_left--;
    end else if (flush) begin
      flush_left = DEPTH;
    end else if (op_valid) begin
      exp_rsp_valid = 1;
      a = int'(op_addr);
      case (op_code)
        2'd0: begin
          n = 0;
          for (int i = 0; i < DEPTH; i++)
            if (mvalid[i] && mdata[i] == op_data) begin
              if (n == 0) exp_addr = i;
              n++;
            end
          exp_hit = (n > 0); exp_multi = (n > 1);
          exp_addr_chk = 1; exp_is_search = 1;
        end
        2'd1: if (a < DEPTH) begin
          mdata[a] = op_data; mvalid[a] = 1;
          exp_hit = 1; exp_addr = a; exp_addr_chk = 1;
        end
        2'd2: if (a < DEPTH) begin
          exp_hit = mvalid[a]; mvalid[a] = 0;
        end
        default: begin
          n = -1;
          for (int i = DEPTH - 1; i >= 0; i--) if (!mvalid[i]) n = i;
          if (n >= 0) begin
            mdata[n] = op_data; mvalid[n] = 1;
            exp_hit = 1; exp_addr = n; exp_addr_chk = 1;
          end
        end
      endcase
    end
    exp_ready = (flush_left == 0);
    exp_count = 0;
    for (int i = 0; i < DEPTH; i++) exp_count += int'(mvalid[i]);
    exp_full = (exp_count == DEPTH);
  end

  // Compare process: checks the DUT against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("op_ready", 32'(op_ready), 32'(exp_ready));
      check("count", 32'(count), 32'(exp_count));
      check("full", 32'(full), 32'(exp_full));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      if (exp_rsp_valid) begin
        check("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
        if (exp_is_search) check("rsp_multi", 32'(rsp_multi), 32'(exp_multi));
        if (exp_addr_chk) check("rsp_addr", 32'(rsp_addr), 32'(exp_addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [1:0] c, input int a, input logic [7:0] d);
    op_valid = 1'b1; op_code = c; op_addr = ADDR_W'(a); op_data = d;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input bit hit, input int addr, input bit chk_addr);
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_hit"}, 32'(rsp_hit), 32'(hit));
    if (chk_addr) check({name, "_addr"}, 32'(rsp_addr), 32'(addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rsp", {rsp_valid, rsp_hit, rsp_multi, 4'(rsp_addr)}, 32'd0);
    rst = 1'b0;
    tick();

    // Allocation order and search with duplicates.
    do_op(2'd3, 0, 8'h11); expect_rsp("alloc0", 1, 0, 1);
    do_op(2'd3, 0, 8'h22); expect_rsp("alloc1", 1, 1, 1);
    do_op(2'd3, 0, 8'h33); expect_rsp("alloc2", 1, 2, 1);
    check("count3", 32'(count), 32'd3);
    do_op(2'd1, 5, 8'h22); expect_rsp("write5", 1, 5, 1);
    do_op(2'd0, 0, 8'h22); expect_rsp("search_dup", 1, 1, 1);
    check("search_dup_multi", 32'(rsp_multi), 32'd1);
    do_op(2'd2, 1, 8'h00); expect_rsp("inval1", 1, 0, 0);
    do_op(2'd0, 0, 8'h22); expect_rsp("search_after_inval", 1, 5, 1);
    check("search_after_inval_multi", 32'(rsp_multi), 32'd0);

    // Out-of-range write and search of an invalidated entry.
    do_op(2'd1, 15, 8'h44); expect_rsp("write_oor", 0, 0, 0);
    check("write_oor_count", 32'(count), 32'd3);
    do_op(2'd2, 2, 8'h00); expect_rsp("inval2", 1, 0, 0);
    do_op(2'd0, 0, 8'h33); expect_rsp("search_stale", 0, 0, 1);

    // Fill to full, then one more allocation must fail.
    do_op(2'd3, 0, 8'h40); expect_rsp("fill_first", 1, 1, 1);
    for (int i = 1; i < 12; i++) do_op(2'd3, 0, 8'h40 + 8'(i));
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd14);
    do_op(2'd3, 0, 8'h99); expect_rsp("alloc_full", 0, 0, 0);
    do_op(2'd0, 0, 8'h99); expect_rsp("search_rejected", 0, 0, 1);
    do_op(2'd0, 0, 8'h4b); expect_rsp("search_last", 1, 13, 1);

    // Flush with a simultaneous search; a second flush pulse is ignored.
    flush = 1'b1; op_valid = 1'b1; op_code = 2'd0; op_data = 8'h11;
    tick();
    flush = 1'b0; op_valid = 1'b0;
    check("flush_no_rsp", 32'(rsp_valid), 32'd0);
    n = 0;
    while (!op_ready && n < 40) begin
      flush = (n == 3);
      n++;
      tick();
    end
    flush = 1'b0;
    check("flush_cycles", 32'(n), 32'd14);
    check("flush_count", 32'(count), 32'd0);
    do_op(2'd0, 0, 8'h11); expect_rsp("flush_miss_a", 0, 0, 1);
    do_op(2'd0, 0, 8'h22); expect_rsp("flush_miss_b", 0, 0, 1);

    // Reset part-way through a flush.
    for (int i = 0; i < 3; i++) do_op(2'd3, 0, 8'h70 + 8'(i));
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_flush_ready", 32'(op_ready), 32'd1);
    check("rst_flush_count", 32'(count), 32'd0);
    check("rst_flush_rsp", 32'(rsp_valid), 32'd0);

    // Reset together with an accepted op: no response follows.
    do_op(2'd3, 0, 8'h55);
    rst = 1'b1; op_valid = 1'b1; op_code = 2'd3; op_data = 8'h66;
    tick();
    rst = 1'b0; op_valid = 1'b0;
    check("rst_op_rsp", 32'(rsp_valid), 32'd0);
    check("rst_op_count", 32'(count), 32'd0);

    // Randomized traffic; the compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      op_valid = ($urandom_range(0, 9) < 7);
      op_code  = 2'($urandom_range(0, 3));
      op_addr  = ADDR_W'($urandom_range(0, 15));
      op_data  = 8'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; flush = 1'b0; op_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
